eprisc_gpr_banked: RTL and testbench
====================================

# eprisc_gpr_banked

Parametrised, paged general-purpose register file for the next-generation epRISC core. It has two symmetric read/write ports. Each port's physical address is `{iPage, iAddr}`, so the core's `CS` register page selects the bank. The block adds a hardware clear sweep after reset or on request, configurable read-during-write bypass, and a defined dual-write collision rule. It sits between the decode/writeback stages and the rest of the datapath. It replaces the fixed 32x256 dual-port array.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width in bits.
- `ADDR_WIDTH`, 4, register index bits within a page.
- `PAGE_WIDTH`, 4, page-select bits. `DEPTH = 2^(PAGE_WIDTH+ADDR_WIDTH)`.
- `BYPASS`, 1. When 1, a read returns same-cycle write data (write-first). When 0, a read returns the old contents (read-first).

Ports:
- `iClk`, in, 1, single clock; all logic on the rising edge.
- `iRst`, in, 1. Reset is asynchronous and active-high.
- `iPage`, in, `PAGE_WIDTH`, page shared by both ports.
- `iAddrA` / `iAddrB`, in, `ADDR_WIDTH`, register index for port A / B.
- `iDInA` / `iDInB`, in, `DATA_WIDTH`, write data for port A / B.
- `iWriteA` / `iWriteB`, in, 1, write enable for port A / B.
- `oDOutA` / `oDOutB`, out, `DATA_WIDTH`, registered read data for port A / B.
- `iClear`, in, 1, single-cycle request to zero the whole array.
- `oBusy`, out, 1, high while a clear sweep runs.

## Operation
- Physical index `PA = {iPage, iAddrA}`, `PB = {iPage, iAddrB}`.
- FSM has two states:
  - `CLEAR`: a counter `rClr` (width `PAGE_WIDTH+ADDR_WIDTH`) writes 0 to entry `rClr` each cycle and increments.
  - `IDLE`: normal operation.
- Transitions:
  - `iRst` asserted forces `CLEAR` with `rClr=0`.
  - `CLEAR` goes to `IDLE` after the cycle that writes entry `DEPTH-1`.
  - `IDLE` goes to `CLEAR` (`rClr=0`) on `iClear=1`.
  - `iClear` while in `CLEAR` is ignored; the sweep does not restart.
- In `CLEAR`:
  - `iWriteA` and `iWriteB` are ignored; no array write occurs from the ports.
  - `oDOutA` and `oDOutB` are held at 0.
- In `IDLE`:
  - Every cycle, each port registers read data for its address, including cycles in which that port writes. This differs from the old array, which froze output during a write.
  - Writes commit at the clock edge.
  - Dual write to the same `PA==PB`: port B wins, and the entry holds `iDInB`.
- Bypass when `BYPASS=1`. Next-cycle `oDOutX` for port X reading address P is, in priority order:
  1. `iDInB` if `iWriteB` and `PB==P`;
  2. else `iDInA` if `iWriteA` and `PA==P`;
  3. else the array contents.
- Bypass when `BYPASS=0`: `oDOutX` is always the pre-write array contents.
- Wrap-around: `rClr` reaching `DEPTH-1` ends the sweep; the counter never wraps into a second pass.

## Timing
- Reset values: `oDOutA=0`, `oDOutB=0`, `oBusy=1`, FSM=`CLEAR`, `rClr=0`. All are applied asynchronously on `iRst`.
- Clear duration:
  - Exactly `DEPTH` rising edges after `iRst` deasserts, or after the edge that samples `iClear`. With default parameters this is 256 cycles.
  - `oBusy` falls on the edge that writes entry `DEPTH-1`.
  - Port operations are accepted on the next edge.
- `oBusy` rises on the same edge that samples `iClear` in `IDLE`. Port writes presented on that edge are still committed. Reads are registered on that edge, and `oDOutX` is forced to 0 from the following edge.
- Read latency is 1 cycle: address/page presented at edge N gives data on `oDOutX` after edge N+1.
- Reset mid-sweep or mid-operation: outputs go to 0 immediately and the sweep restarts from entry 0. Array contents are undefined until the sweep completes.

## Test plan
- Reset and sweep: hold `iRst` 3 cycles, release. Required: `oBusy=1` for 256 edges, then 0. Reading every `{page,addr}` returns 0.
- Page isolation: A writes `0xDEADBEEF` to page 2, addr 5. Then B reads page 2, addr 5 and gets `0xDEADBEEF` one cycle later. Page 3, addr 5 reads 0.
- Bypass: B writes `0x00001234` to addr 7 while A reads addr 7 (old value `0xAAAA0000`). Required next-cycle `oDOutA`: `0x00001234` with `BYPASS=1`, `0xAAAA0000` with `BYPASS=0`.
- Collision: A writes `0x11111111` and B writes `0x22222222` to the same address in the same cycle. Required: a later read returns `0x22222222`, and with `BYPASS=1` both outputs show `0x22222222` on the next cycle.
- Clear request: fill 10 registers, pulse `iClear`, and attempt a write of `0x55` during the sweep. Required: `oBusy` is high for 256 cycles, outputs are 0 throughout, and all entries read 0 afterwards, including the write target.
- Reset mid-sweep: assert `iRst` at sweep cycle 100. Required: outputs are 0 immediately, and after release `oBusy` stays high a full 256 cycles.

Source files
------------

// File: rtl/eprisc_gpr_banked.sv
// epRISC paged general-purpose register file: two symmetric read/write
// ports, page-selected banks, a hardware clear sweep, optional bypass.
//
// Ports:
//   iClk, iRst          clock, asynchronous active-high reset
//   iPage               page (bank) select shared by both ports
//   iAddrA / iAddrB     register index within the page
//   iDInA / iDInB       write data
//   iWriteA / iWriteB   write enables
//   oDOutA / oDOutB     registered read data, one cycle latency
//   iClear              single-cycle request to zero the whole array
//   oBusy               high while the clear sweep runs
module eprisc_gpr_banked #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int PAGE_WIDTH = 4,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [PAGE_WIDTH-1:0] iPage,
    input  logic [ADDR_WIDTH-1:0] iAddrA,
    input  logic [ADDR_WIDTH-1:0] iAddrB,
    input  logic [DATA_WIDTH-1:0] iDInA,
    input  logic [DATA_WIDTH-1:0] iDInB,
    input  logic                  iWriteA,
    input  logic                  iWriteB,
    output logic [DATA_WIDTH-1:0] oDOutA,
    output logic [DATA_WIDTH-1:0] oDOutB,
    input  logic                  iClear,
    output logic                  oBusy
);

    localparam int IW    = PAGE_WIDTH + ADDR_WIDTH;
    localparam int DEPTH = 1 << IW;

    localparam logic [IW-1:0] CLR_LAST = '1;
    localparam logic [IW-1:0] CLR_ONE  = IW'(1);

    typedef enum logic {
        CLEAR,
        IDLE
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [IW-1:0]         rClr;
    logic [IW-1:0]         nextClr;
    logic                  sweepWr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]         pa;
    logic [IW-1:0]         pb;
    logic                  isIdle;
    logic                  wrA;
    logic                  wrB;
    logic [DATA_WIDTH-1:0] rdA;
    logic [DATA_WIDTH-1:0] rdB;

    assign pa     = {iPage, iAddrA};
    assign pb     = {iPage, iAddrB};
    assign isIdle = (state == IDLE);
    assign oBusy  = (state == CLEAR);

    // Port B wins a same-address dual write, so A is suppressed there.
    assign wrB = isIdle && iWriteB;
    assign wrA = isIdle && iWriteA && !(iWriteB && (pa == pb));

    // State and sweep counter
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= CLEAR;
            rClr  <= '0;
        end else begin
            state <= nextState;
            rClr  <= nextClr;
        end
    end

    always_comb begin
        nextState = state;
        nextClr   = rClr;
        sweepWr   = 1'b0;
        unique case (state)
            CLEAR: begin
                sweepWr = 1'b1;
                if (rClr == CLR_LAST) begin
                    nextState = IDLE;
                    nextClr   = '0;
                end else begin
                    nextClr = rClr + CLR_ONE;
                end
            end
            IDLE: begin
                if (iClear) begin
                    nextState = CLEAR;
                    nextClr   = '0;
                end
            end
            default: begin
                nextState = CLEAR;
                nextClr   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge iClk) begin
        if (sweepWr) begin
            mem[rClr] <= '0;
        end else begin
            if (wrA) mem[pa] <= iDInA;
            if (wrB) mem[pb] <= iDInB;
        end
    end

    // Read-data selection; B's write data outranks A's when bypassing.
    always_comb begin
        rdA = mem[pa];
        rdB = mem[pb];
        if (BYPASS) begin
            if (wrB && (pb == pa)) begin
                rdA = iDInB;
            end else if (wrA) begin
                rdA = iDInA;
            end
            if (wrB) begin
                rdB = iDInB;
            end else if (wrA && (pa == pb)) begin
                rdB = iDInA;
            end
        end
    end

    // Output registers: forced to zero whenever a sweep is running.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDOutA <= '0;
            oDOutB <= '0;
        end else if (!isIdle) begin
            oDOutA <= '0;
            oDOutB <= '0;
        end else begin
            oDOutA <= rdA;
            oDOutB <= rdB;
        end
    end

endmodule

// File: tb/tb_eprisc_gpr_banked.sv
// Self-checking bench for eprisc_gpr_banked: one write-first and one
// read-first instance share stimulus and a behavioural reference model.
module tb_eprisc_gpr_banked;

    logic        iClk;
    logic        iRst;
    logic [3:0]  iPage;
    logic [3:0]  iAddrA;
    logic [3:0]  iAddrB;
    logic [31:0] iDInA;
    logic [31:0] iDInB;
    logic        iWriteA;
    logic        iWriteB;
    logic        iClear;

    logic [31:0] doA1, doB1, doA0, doB0;
    logic        busy1, busy0;

    int errors = 0;
    int checks = 0;

    logic [31:0] refMem [256];
    int          remaining;
    logic [31:0] eA1, eB1, eA0, eB0;

    eprisc_gpr_banked #(.BYPASS(1'b1)) u1 (
        .iClk(iClk), .iRst(iRst), .iPage(iPage),
        .iAddrA(iAddrA), .iAddrB(iAddrB),
        .iDInA(iDInA), .iDInB(iDInB),
        .iWriteA(iWriteA), .iWriteB(iWriteB),
        .oDOutA(doA1), .oDOutB(doB1),
        .iClear(iClear), .oBusy(busy1)
    );

    eprisc_gpr_banked #(.BYPASS(1'b0)) u0 (
        .iClk(iClk), .iRst(iRst), .iPage(iPage),
        .iAddrA(iAddrA), .iAddrB(iAddrB),
        .iDInA(iDInA), .iDInB(iDInB),
        .iWriteA(iWriteA), .iWriteB(iWriteB),
        .oDOutA(doA0), .oDOutB(doB0),
        .iClear(iClear), .oBusy(busy0)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reset: outputs zero at once, a full sweep pending.
    task automatic modelReset();
        eA1 = '0; eB1 = '0; eA0 = '0; eB0 = '0;
        remaining = 256;
        for (int i = 0; i < 256; i++) refMem[i] = '0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic modelEdge();
        int pa, pb;
        logic [31:0] oldA, oldB;
        if (iRst) return;
        if (remaining > 0) begin
            remaining--;
            eA1 = '0; eB1 = '0; eA0 = '0; eB0 = '0;
            return;
        end
        pa = int'({iPage, iAddrA});
        pb = int'({iPage, iAddrB});
        oldA = refMem[pa];
        oldB = refMem[pb];
        eA0 = oldA;
        eB0 = oldB;
        eA1 = (iWriteB && pb == pa) ? iDInB : (iWriteA ? iDInA : oldA);
        eB1 = iWriteB ? iDInB : ((iWriteA && pa == pb) ? iDInA : oldB);
        if (iWriteA) refMem[pa] = iDInA;
        if (iWriteB) refMem[pb] = iDInB;
        if (iClear) begin
            remaining = 256;
            for (int i = 0; i < 256; i++) refMem[i] = '0;
        end
    endtask

    task automatic checkAll();
        logic [31:0] eb;
        eb = (remaining > 0) ? 32'd1 : 32'd0;
        chk("busy1", {31'd0, busy1}, eb);
        chk("busy0", {31'd0, busy0}, eb);
        chk("doA1", doA1, eA1);
        chk("doB1", doB1, eB1);
        chk("doA0", doA0, eA0);
        chk("doB0", doB0, eB0);
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
        modelEdge();
        checkAll();
    endtask

    task automatic idleInputs();
        iWriteA = 1'b0; iWriteB = 1'b0; iClear = 1'b0;
    endtask

    // Step until busy falls, counting busy edges; bounded.
    task automatic countSweep(input string tag);
        int n;
        n = 0;
        while (busy1 && n < 400) begin
            step();
            n++;
        end
        chk(tag, n, 32'd256);
    endtask

    task automatic readAll(input string tag);
        for (int i = 0; i < 256; i++) begin
            {iPage, iAddrA} = 8'(i);
            iAddrB = iAddrA;
            step();
            chk(tag, doA1 | doB0, 32'd0);
        end
    endtask

    initial begin
        iRst = 1'b1; iPage = '0; iAddrA = '0; iAddrB = '0;
        iDInA = '0; iDInB = '0;
        idleInputs();
        modelReset();
        #1;
        checkAll();
        step(); step(); step();

        // Release reset and count the sweep.
        iRst = 1'b0;
        countSweep("sweepLen");
        chk("busyAfter", {31'd0, busy1}, 32'd0);
        readAll("zeroAfterReset");

        // Page isolation
        iPage = 4'd2; iAddrA = 4'd5; iDInA = 32'hDEADBEEF; iWriteA = 1'b1;
        step();
        idleInputs();
        iAddrB = 4'd5;
        step();
        chk("pageB", doB1, 32'hDEADBEEF);
        iPage = 4'd3;
        step();
        chk("pageOther", doB1, 32'd0);

        // Bypass
        iPage = 4'd0; iAddrA = 4'd7; iDInA = 32'hAAAA0000; iWriteA = 1'b1;
        step();
        idleInputs();
        iAddrB = 4'd7; iDInB = 32'h00001234; iWriteB = 1'b1;
        step();
        chk("bypass1", doA1, 32'h00001234);
        chk("bypass0", doA0, 32'hAAAA0000);
        idleInputs();

        // Collision
        iAddrA = 4'd9; iAddrB = 4'd9;
        iDInA = 32'h11111111; iDInB = 32'h22222222;
        iWriteA = 1'b1; iWriteB = 1'b1;
        step();
        chk("collA1", doA1, 32'h22222222);
        chk("collB1", doB1, 32'h22222222);
        idleInputs();
        step();
        chk("collRd", doA0, 32'h22222222);

        // Random traffic on a few pages for more address reuse.
        for (int i = 0; i < 400; i++) begin
            iPage   = 4'($urandom_range(0, 2));
            iAddrA  = 4'($urandom);
            iAddrB  = 4'($urandom_range(0, 3)) + iAddrA;
            iDInA   = $urandom;
            iDInB   = $urandom;
            iWriteA = ($urandom_range(0, 2) == 0);
            iWriteB = ($urandom_range(0, 2) == 0);
            step();
        end
        idleInputs();

        // Clear request with writes attempted during the sweep.
        iPage = 4'd1;
        for (int i = 0; i < 10; i++) begin
            iAddrA = 4'(i); iDInA = 32'hC0DE0000 + 32'(i); iWriteA = 1'b1;
            step();
        end
        iWriteA = 1'b0;
        iClear = 1'b1;
        step();
        chk("clearBusy", {31'd0, busy1}, 32'd1);
        iClear = 1'b0;
        iAddrA = 4'd3; iDInA = 32'h55; iWriteA = 1'b1;
        for (int i = 0; i < 255; i++) begin
            iClear = (i == 50);
            step();
        end
        chk("clearLast", {31'd0, busy1}, 32'd1);
        step();
        chk("clearDone", {31'd0, busy1}, 32'd0);
        idleInputs();
        readAll("zeroAfterClear");

        // Reset mid-sweep
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        for (int i = 0; i < 100; i++) step();
        #2;
        iRst = 1'b1;
        modelReset();
        #1;
        checkAll();
        step(); step();
        iRst = 1'b0;
        countSweep("sweepAfterRst");

        // Reset mid-operation: nonzero outputs drop immediately.
        iPage = 4'd4; iAddrA = 4'd1; iAddrB = 4'd1;
        iDInA = 32'hFEEDF00D; iWriteA = 1'b1;
        step();
        idleInputs();
        step();
        chk("preRst", doA0, 32'hFEEDF00D);
        #2;
        iRst = 1'b1;
        modelReset();
        #1;
        checkAll();
        step();
        iRst = 1'b0;
        countSweep("sweepAfterRst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
